mux_info_sel: RTL and testbench
===============================

# mux_info_sel

Registered 2:1 selector for two 4-digit BCD display values. It chooses between the primary number (`numero`) and the secondary/saved number (`numero_sv`) under control of `ent`, and presents the chosen value as a registered 4-digit output. That output feeds the display-driver path. It also reports which source is selected, flags non-BCD digits, and pulses when the displayed value changes. The module is named `mux_info_sel`.

## Interface

- No parameters. Widths are fixed: 4 digits of 4 bits each.
- `clk`  in  1  Single system clock; rising-edge active.
- `rst`  in  1  Reset. Asynchronous, active-high.
- `ent`  in  1  Source select.
  - 0 selects `numero`.
  - 1 selects `numero_sv`.
- `numero`  in  [3:0][3:0]  Primary value, packed BCD.
  - Digit [3] is the most significant (thousands); digit [0] is the units.
- `numero_sv`  in  [3:0][3:0]  Secondary/saved value, same packing as `numero`.
- `s_mux`  out  [3:0][3:0]  Registered selected value, same packing.
- `sel_q`  out  1  Registered copy of `ent`; always matches the source currently shown on `s_mux`.
- `digit_err`  out  [3:0]  Registered flags. Bit i is 1 when `s_mux` digit i is greater than 9.
- `upd`  out  1  One-cycle pulse. Asserted for the cycle after `s_mux` takes a value different from its previous value.

## Operation

- Combinational select: `nxt = ent ? numero_sv : numero`, computed over all 16 bits. Digit order is preserved; no digits are swapped.
- On each rising `clk` edge with `rst` low, all outputs register together:
  - `s_mux` <= `nxt`
  - `sel_q` <= `ent`
  - `digit_err[i]` <= (`nxt[i]` > 9)
  - `upd` <= (`nxt` != current `s_mux`)
- Invalid BCD digits (0xA–0xF) pass through to `s_mux` unchanged; they are only flagged on `digit_err`. No clamping or correction is applied.
- There is no FSM. The module holds only the output registers.
- `ent`, `numero` and `numero_sv` are treated as synchronous to `clk`. No synchronizers are included.
- X or undriven inputs are not masked. The implementation must not add latches.

## Timing

- Asynchronous reset: while `rst` is high, the outputs hold these values, independent of `clk`:
  - `s_mux` = 16'h0000
  - `sel_q` = 0
  - `digit_err` = 4'b0000
  - `upd` = 0
- Reset release: the first rising edge with `rst` low loads `nxt`.
  - `upd` asserts on that edge if `nxt` != 0.
- Latency is 1 cycle from input to output.
  - An `ent` or data change that is set up before edge N appears on the outputs just after edge N.
  - An input that changes on or after edge N appears after edge N+1.
- Simultaneous `ent` and data changes: the value registered is whatever the combinational select produces at the sampling edge.
- Stable inputs: outputs hold, and `upd` stays 0 from the second cycle onward.
- Reset asserted mid-operation: outputs clear immediately, with no wait for a clock edge. Any pending update is discarded.
- `upd` is high for exactly one cycle per change. If the value changes every cycle, `upd` stays high continuously.

## Test plan

- Reset and hold:
  - Stimulus: `rst`=1 for 3 cycles with `numero`=2605 and `ent`=0.
  - Required: `s_mux`=0000, `sel_q`=0, `digit_err`=0 and `upd`=0 throughout.
  - Then release `rst`. Required: one edge later `s_mux`=2,6,0,5 (digit [3]..[0]) and `upd`=1 for one cycle.
- Select primary:
  - Stimulus: `ent`=0, `numero`={2,6,0,5}, `numero_sv`={1,0,4,6}.
  - Required: one edge later, `s_mux` reads 0010 0110 0000 0101 and `sel_q`=0.
- Switch to secondary:
  - Stimulus: `ent`→1 with data held.
  - Required: within 2 edges `s_mux` reads 0001 0000 0100 0110, `sel_q`=1, and `upd` pulses exactly once.
  - Then `ent`→0. Required: `s_mux` returns to 2605 within 2 edges.
- Invalid digit:
  - Stimulus: `numero`={0xC,6,0,5} with `ent`=0.
  - Required: `s_mux[3]`=4'hC and `digit_err`=4'b1000.
  - Then select `numero_sv`={1,0,4,6}. Required: `digit_err`=0.
- Async reset mid-run:
  - Stimulus: assert `rst` between clock edges while `s_mux`=1046.
  - Required: outputs clear to 0 before the next rising edge.
- Unselected-input isolation:
  - Stimulus: toggle `numero_sv` every cycle while `ent`=0 and `numero` is constant.
  - Required: `s_mux` stays constant and `upd` stays 0.

Source files
------------

// File: rtl/mux_info_sel.sv
// Registered 2:1 selector for two 4-digit BCD display values, with source tag,
// per-digit non-BCD flags and a one-cycle pulse whenever the shown value changes.
module mux_info_sel (
    input  logic            clk,
    input  logic            rst,
    input  logic            ent,
    input  logic [3:0][3:0] numero,
    input  logic [3:0][3:0] numero_sv,
    output logic [3:0][3:0] s_mux,
    output logic            sel_q,
    output logic [3:0]      digit_err,
    output logic            upd
);

    logic [3:0][3:0] nxt;
    logic [3:0]      nxt_err;
    logic            nxt_upd;

    always_comb begin
        nxt = ent ? numero_sv : numero;
        nxt_err = '0;
        for (int i = 0; i < 4; i++) begin
            nxt_err[i] = (nxt[i] > 4'd9);
        end
        // Compare against the value currently shown, not the previous input.
        nxt_upd = (nxt != s_mux);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_mux     <= '0;
            sel_q     <= 1'b0;
            digit_err <= '0;
            upd       <= 1'b0;
        end else begin
            s_mux     <= nxt;
            sel_q     <= ent;
            digit_err <= nxt_err;
            upd       <= nxt_upd;
        end
    end

endmodule

// File: tb/tb_mux_info_sel.sv
// Directed self-checking bench for mux_info_sel: inputs change 1 ns after a
// rising edge, outputs are sampled 1 ns after the following rising edge.
module tb_mux_info_sel;

    logic            clk;
    logic            rst;
    logic            ent;
    logic [3:0][3:0] numero;
    logic [3:0][3:0] numero_sv;
    logic [3:0][3:0] s_mux;
    logic            sel_q;
    logic [3:0]      digit_err;
    logic            upd;

    int checks;
    int errors;

    mux_info_sel dut (
        .clk       (clk),
        .rst       (rst),
        .ent       (ent),
        .numero    (numero),
        .numero_sv (numero_sv),
        .s_mux     (s_mux),
        .sel_q     (sel_q),
        .digit_err (digit_err),
        .upd       (upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        ent       = 1'b0;
        numero    = 16'h2605;
        numero_sv = 16'h1046;
        #2;
        checks++;
        if ({s_mux, sel_q, digit_err, upd} !== 22'h0) begin
            errors++;
            $display("FAIL reset_async: got s_mux=%h sel_q=%b err=%b upd=%b, want all zero", s_mux, sel_q, digit_err, upd);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({s_mux, sel_q, digit_err, upd} !== 22'h0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got s_mux=%h sel_q=%b err=%b upd=%b, want all zero", i, s_mux, sel_q, digit_err, upd);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (s_mux !== 16'h2605 || upd !== 1'b1 || sel_q !== 1'b0 || digit_err !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release: got s_mux=%h upd=%b sel_q=%b err=%b, want 2605 1 0 0000", s_mux, upd, sel_q, digit_err);
        end
        step();
        checks++;
        if (s_mux !== 16'h2605 || upd !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_hold: got s_mux=%h upd=%b, want 2605 0", s_mux, upd);
        end
    endtask

    task automatic test_select_primary();
        ent       = 1'b0;
        numero    = 16'h2605;
        numero_sv = 16'h1046;
        step();
        checks++;
        if (s_mux !== 16'b0010_0110_0000_0101 || sel_q !== 1'b0 || upd !== 1'b0) begin
            errors++;
            $display("FAIL select_primary: got s_mux=%h sel_q=%b upd=%b, want 2605 0 0", s_mux, sel_q, upd);
        end
    endtask

    task automatic test_switch_secondary();
        int pulses;
        pulses = 0;
        ent = 1'b1;
        step();
        checks++;
        if (s_mux !== 16'b0001_0000_0100_0110 || sel_q !== 1'b1 || upd !== 1'b1) begin
            errors++;
            $display("FAIL switch_secondary: got s_mux=%h sel_q=%b upd=%b, want 1046 1 1", s_mux, sel_q, upd);
        end
        if (upd === 1'b1) pulses++;
        step();
        if (upd === 1'b1) pulses++;
        checks++;
        if (pulses != 1 || s_mux !== 16'h1046) begin
            errors++;
            $display("FAIL switch_pulse_count: got pulses=%0d s_mux=%h, want 1 1046", pulses, s_mux);
        end
        ent = 1'b0;
        step();
        checks++;
        if (s_mux !== 16'h2605 || sel_q !== 1'b0 || upd !== 1'b1) begin
            errors++;
            $display("FAIL switch_back_primary: got s_mux=%h sel_q=%b upd=%b, want 2605 0 1", s_mux, sel_q, upd);
        end
    endtask

    task automatic test_invalid_digit();
        ent    = 1'b0;
        numero = 16'hC605;
        step();
        checks++;
        if (s_mux[3] !== 4'hC || s_mux !== 16'hC605 || digit_err !== 4'b1000) begin
            errors++;
            $display("FAIL invalid_msd: got s_mux=%h err=%b, want C605 1000", s_mux, digit_err);
        end
        numero = 16'h9A9A;
        step();
        checks++;
        if (s_mux !== 16'h9A9A || digit_err !== 4'b0101) begin
            errors++;
            $display("FAIL invalid_mixed: got s_mux=%h err=%b, want 9A9A 0101", s_mux, digit_err);
        end
        numero = 16'hFFFF;
        step();
        checks++;
        if (s_mux !== 16'hFFFF || digit_err !== 4'b1111) begin
            errors++;
            $display("FAIL invalid_all: got s_mux=%h err=%b, want FFFF 1111", s_mux, digit_err);
        end
        ent = 1'b1;
        step();
        checks++;
        if (s_mux !== 16'h1046 || digit_err !== 4'b0000 || sel_q !== 1'b1) begin
            errors++;
            $display("FAIL invalid_clear: got s_mux=%h err=%b sel_q=%b, want 1046 0000 1", s_mux, digit_err, sel_q);
        end
    endtask

    task automatic test_async_reset();
        numero = 16'h2605;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({s_mux, sel_q, digit_err, upd} !== 22'h0) begin
            errors++;
            $display("FAIL async_reset_mid: got s_mux=%h sel_q=%b err=%b upd=%b, want all zero", s_mux, sel_q, digit_err, upd);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (s_mux !== 16'h1046 || upd !== 1'b1 || sel_q !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_recover: got s_mux=%h upd=%b sel_q=%b, want 1046 1 1", s_mux, upd, sel_q);
        end
    endtask

    task automatic test_isolation();
        ent    = 1'b0;
        numero = 16'h2605;
        step();
        checks++;
        if (s_mux !== 16'h2605 || upd !== 1'b1) begin
            errors++;
            $display("FAIL isolation_setup: got s_mux=%h upd=%b, want 2605 1", s_mux, upd);
        end
        for (int i = 0; i < 6; i++) begin
            numero_sv = (i % 2 == 0) ? 16'h9999 : 16'h1234;
            step();
            checks++;
            if (s_mux !== 16'h2605 || upd !== 1'b0) begin
                errors++;
                $display("FAIL isolation[%0d]: got s_mux=%h upd=%b, want 2605 0", i, s_mux, upd);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [4];
        vals[0] = 16'h0001;
        vals[1] = 16'h0002;
        vals[2] = 16'h0010;
        vals[3] = 16'h1000;
        ent = 1'b0;
        for (int i = 0; i < 4; i++) begin
            numero = vals[i];
            step();
            checks++;
            if (s_mux !== vals[i] || upd !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got s_mux=%h upd=%b, want %h 1", i, s_mux, upd, vals[i]);
            end
        end
        step();
        checks++;
        if (s_mux !== 16'h1000 || upd !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_settle: got s_mux=%h upd=%b, want 1000 0", s_mux, upd);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_select_primary();
        test_switch_secondary();
        test_invalid_digit();
        test_async_reset();
        test_isolation();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
